pampy_control_unit: RTL and testbench
=====================================

# pampy_control_unit

Microcoded fetch/decode/execute sequencer for the pamPy stack processor. It drives every mux-select and register-enable of the ULA, PC/instruction/argument and stack/TOS blocks, one micro-state per clock. It runs a Python-bytecode subset using REG_INSTR, REG_ARG and the ULA comparison/overflow flags, and reports completion, halt and fault status to the top level.

## Interface
- DATA_WIDTH, 8, width of instruction opcode and argument.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- START  in  1  leaves IDLE when high.
- INSTR_IN  in  DATA_WIDTH  opcode from REG_INSTR.
- ARG_IN  in  DATA_WIDTH  argument from REG_ARG.
- COMP_IN  in  1  ULA comparison flag register.
- OVERFLOW_IN  in  1  ULA overflow flag register.
- SEL_MUX_OP1  out  2  0 = stack read, 1 = jump reg.
- SEL_MUX_OP2  out  2  0 = stack read, 1 = arg, 2 = TOS, 3 = PC.
- CTRL_REG_OP1, CTRL_REG_OP2  out  1 each  operand register load.
- SEL_ULA  out  4  0 add, 1 sub, 2 mul, 4 inc (op2+1), 5 pass op2, 8+k compare k (k = 0..5).
- CTRL_REG_INSTR, CTRL_REG_ARG  out  1 each  load instruction/argument from program memory at PC.
- CTRL_REG_PC  out  1  PC load.
- SEL_MUX_PC  out  1  0 = ULA_OUT.
- SEL_MUX_STACK  out  2  0 = arg, 3 = ULA_OUT.
- CTRL_REG_STACK  out  2  00 hold, 01 read top, 10 push, 11 pop.
- CTRL_STACK  out  1  stack write strobe.
- INSTR_DONE  out  1  one-cycle pulse on the instruction's last cycle.
- HALTED, FAULT  out  1 each  sticky status.

## Operation
- Moore FSM. Outputs decode from the state register plus the opcode class and compare code latched in DECODE. Any output not listed for a state is 0.
- IDLE: wait for START=1, then go to FETCH.
- FETCH: CTRL_REG_INSTR=CTRL_REG_ARG=1. Then DECODE.
- DECODE: classify INSTR_IN/ARG_IN. No control outputs asserted.
- PC_OP: SEL_MUX_OP2=3, CTRL_REG_OP2=1.
- PC_WR: SEL_ULA=4, SEL_MUX_PC=0, CTRL_REG_PC=1, INSTR_DONE=1. Then FETCH.
- NOP (9): DECODE→PC_OP→PC_WR.
- LOAD_CONST (100): PUSH (SEL_MUX_STACK=0, CTRL_REG_STACK=10, CTRL_STACK=1)→PC_OP→PC_WR.
- POP_TOP (1): POP (CTRL_REG_STACK=11)→PC_OP→PC_WR.
- BINARY_MULTIPLY (20), BINARY_ADD (23), BINARY_SUBTRACT (24), COMPARE_OP (107):
  - RD_B: CTRL_REG_STACK=01.
  - LD_B: SEL_MUX_OP2=0, CTRL_REG_OP2=1, CTRL_REG_STACK=11.
  - RD_A: CTRL_REG_STACK=01.
  - LD_A: SEL_MUX_OP1=0, CTRL_REG_OP1=1, CTRL_REG_STACK=11.
  - ALU_WB: SEL_ULA = 2/0/1/8+ARG[2:0], SEL_MUX_STACK=3, CTRL_REG_STACK=10, CTRL_STACK=1.
  - Then PC_OP→PC_WR.
- JUMP_ABSOLUTE (113): J_OP (SEL_MUX_OP2=1, CTRL_REG_OP2=1)→J_WR (SEL_ULA=5, SEL_MUX_PC=0, CTRL_REG_PC=1, INSTR_DONE=1)→FETCH.
- POP_JUMP_IF_FALSE (114): POP state samples COMP_IN. 0 → J_OP→J_WR; 1 → PC_OP→PC_WR.
- Opcode 0: HALT state, HALTED=1.
- Any other opcode, or COMPARE_OP with ARG_IN[2:0]>5: FAULT state, FAULT=1, detected in DECODE.
- Overflow: arithmetic ops (20/23/24) sample OVERFLOW_IN in the PC_OP following ALU_WB. If 1, go to FAULT instead of PC_WR; no PC load, no INSTR_DONE.
- HALT and FAULT keep all controls 0, ignore START, and exit only on reset.

## Timing
- Reset forces IDLE asynchronously. All outputs, including HALTED and FAULT, are 0 while reset is high and on the first cycle after release.
- Cycle counts from FETCH to INSTR_DONE inclusive: NOP 4, JUMP_ABSOLUTE 4, LOAD_CONST 5, POP_TOP 5, POP_JUMP_IF_FALSE 5, binary/compare 9.
- START is sampled only in IDLE. After the first START, the unit free-runs: FETCH follows PC_WR/J_WR with no bubble.
- INSTR_IN/ARG_IN are sampled only in DECODE. The class is latched, so later changes in REG_INSTR do not affect the running sequence.
- COMP_IN is sampled only in the POP state of opcode 114. OVERFLOW_IN is sampled only in PC_OP after ALU_WB.
- Reset mid-instruction aborts immediately. No partial strobe is completed. Restart requires START.

## Test plan
- Reset, START=1, opcode 100 arg 5 → cycle 1 FETCH strobes; cycle 3 SEL_MUX_STACK=0, CTRL_REG_STACK=10, CTRL_STACK=1; INSTR_DONE=1 in cycle 5; FETCH again in cycle 6.
- Opcode 23 → pops in cycles 4 and 6 (CTRL_REG_STACK=11); cycle 7 SEL_ULA=0, SEL_MUX_STACK=3, push; INSTR_DONE in cycle 9.
- Opcode 107 arg 2 → ALU_WB SEL_ULA=4'hA. Opcode 107 arg 6 → FAULT=1 after DECODE, all controls 0, START ignored.
- Opcode 114 with COMP_IN=0 → cycle 4 SEL_MUX_OP2=1, cycle 5 SEL_ULA=5 + CTRL_REG_PC. With COMP_IN=1 → SEL_MUX_OP2=3, then SEL_ULA=4. Both take 5 cycles.
- Opcode 20 with OVERFLOW_IN=1 at cycle 8 → FAULT=1, CTRL_REG_PC never asserted, INSTR_DONE stays 0.
- Opcode 0 → HALTED=1 stays high. Separately, reset asserted during LD_A → all outputs 0 in the same cycle; after release, IDLE until START.

Source files
------------

// File: rtl/pampy_control_unit.sv
// Microcoded fetch/decode/execute sequencer for the pamPy stack processor.
// It is a Moore FSM: every control strobe decodes from the current micro-state and the opcode class latched in DECODE.
module pampy_control_unit #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  START,
   input  logic [DATA_WIDTH-1:0] INSTR_IN,
   input  logic [DATA_WIDTH-1:0] ARG_IN,
   input  logic                  COMP_IN,
   input  logic                  OVERFLOW_IN,
   output logic [1:0]            SEL_MUX_OP1,
   output logic [1:0]            SEL_MUX_OP2,
   output logic                  CTRL_REG_OP1,
   output logic                  CTRL_REG_OP2,
   output logic [3:0]            SEL_ULA,
   output logic                  CTRL_REG_INSTR,
   output logic                  CTRL_REG_ARG,
   output logic                  CTRL_REG_PC,
   output logic                  SEL_MUX_PC,
   output logic [1:0]            SEL_MUX_STACK,
   output logic [1:0]            CTRL_REG_STACK,
   output logic                  CTRL_STACK,
   output logic                  INSTR_DONE,
   output logic                  HALTED,
   output logic                  FAULT
);

   localparam logic [DATA_WIDTH-1:0] OP_HALT  = DATA_WIDTH'(0);
   localparam logic [DATA_WIDTH-1:0] OP_POP   = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] OP_NOP   = DATA_WIDTH'(9);
   localparam logic [DATA_WIDTH-1:0] OP_MUL   = DATA_WIDTH'(20);
   localparam logic [DATA_WIDTH-1:0] OP_ADD   = DATA_WIDTH'(23);
   localparam logic [DATA_WIDTH-1:0] OP_SUB   = DATA_WIDTH'(24);
   localparam logic [DATA_WIDTH-1:0] OP_CONST = DATA_WIDTH'(100);
   localparam logic [DATA_WIDTH-1:0] OP_CMP   = DATA_WIDTH'(107);
   localparam logic [DATA_WIDTH-1:0] OP_JUMP  = DATA_WIDTH'(113);
   localparam logic [DATA_WIDTH-1:0] OP_PJIF  = DATA_WIDTH'(114);

   typedef enum logic [3:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_PC_OP, ST_PC_WR, ST_PUSH, ST_POP, ST_RD_B,
      ST_LD_B, ST_RD_A, ST_LD_A, ST_ALU_WB, ST_J_OP, ST_J_WR, ST_HALT, ST_FAULT
   } state_t;

   typedef enum logic [3:0] {
      CL_HALT, CL_NOP, CL_LOAD, CL_POPTOP, CL_ARITH, CL_CMP, CL_JUMP, CL_PJIF, CL_BAD
   } class_t;

   state_t     r_state;
   state_t     w_nextState;
   class_t     r_class;
   class_t     w_class;
   logic [3:0] r_aluSel;
   logic [3:0] w_aluSel;
   logic       w_unusedArgBits;

   // Only the low three argument bits carry a compare code.
   assign w_unusedArgBits = ^ARG_IN[DATA_WIDTH-1:3];

   always_comb begin
      w_class  = CL_BAD;
      w_aluSel = 4'd0;
      case (INSTR_IN)
         OP_HALT:  w_class = CL_HALT;
         OP_NOP:   w_class = CL_NOP;
         OP_CONST: w_class = CL_LOAD;
         OP_POP:   w_class = CL_POPTOP;
         OP_MUL:   begin w_class = CL_ARITH; w_aluSel = 4'd2; end
         OP_ADD:   begin w_class = CL_ARITH; w_aluSel = 4'd0; end
         OP_SUB:   begin w_class = CL_ARITH; w_aluSel = 4'd1; end
         OP_CMP: begin
            if (ARG_IN[2:0] <= 3'd5) begin
               w_class  = CL_CMP;
               w_aluSel = {1'b1, ARG_IN[2:0]};
            end
         end
         OP_JUMP:  w_class = CL_JUMP;
         OP_PJIF:  w_class = CL_PJIF;
         default:  w_class = CL_BAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_class  <= CL_NOP;
         r_aluSel <= 4'd0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_DECODE) begin
            r_class  <= w_class;
            r_aluSel <= w_aluSel;
         end
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:   if (START) w_nextState = ST_FETCH;
         ST_FETCH:  w_nextState = ST_DECODE;
         ST_DECODE: begin
            case (w_class)
               CL_HALT:   w_nextState = ST_HALT;
               CL_NOP:    w_nextState = ST_PC_OP;
               CL_LOAD:   w_nextState = ST_PUSH;
               CL_POPTOP: w_nextState = ST_POP;
               CL_ARITH:  w_nextState = ST_RD_B;
               CL_CMP:    w_nextState = ST_RD_B;
               CL_JUMP:   w_nextState = ST_J_OP;
               CL_PJIF:   w_nextState = ST_POP;
               default:   w_nextState = ST_FAULT;
            endcase
         end
         ST_PUSH:   w_nextState = ST_PC_OP;
         // A false condition takes the jump; a true one falls through to PC+1.
         ST_POP:    w_nextState = (r_class == CL_PJIF && !COMP_IN) ? ST_J_OP : ST_PC_OP;
         ST_RD_B:   w_nextState = ST_LD_B;
         ST_LD_B:   w_nextState = ST_RD_A;
         ST_RD_A:   w_nextState = ST_LD_A;
         ST_LD_A:   w_nextState = ST_ALU_WB;
         ST_ALU_WB: w_nextState = ST_PC_OP;
         ST_PC_OP:  w_nextState = (r_class == CL_ARITH && OVERFLOW_IN) ? ST_FAULT : ST_PC_WR;
         ST_PC_WR:  w_nextState = ST_FETCH;
         ST_J_OP:   w_nextState = ST_J_WR;
         ST_J_WR:   w_nextState = ST_FETCH;
         ST_HALT:   w_nextState = ST_HALT;
         ST_FAULT:  w_nextState = ST_FAULT;
         default:   w_nextState = ST_IDLE;
      endcase
   end

   always_comb begin
      SEL_MUX_OP1    = 2'd0;
      SEL_MUX_OP2    = 2'd0;
      CTRL_REG_OP1   = 1'b0;
      CTRL_REG_OP2   = 1'b0;
      SEL_ULA        = 4'd0;
      CTRL_REG_INSTR = 1'b0;
      CTRL_REG_ARG   = 1'b0;
      CTRL_REG_PC    = 1'b0;
      SEL_MUX_PC     = 1'b0;
      SEL_MUX_STACK  = 2'd0;
      CTRL_REG_STACK = 2'b00;
      CTRL_STACK     = 1'b0;
      INSTR_DONE     = 1'b0;
      HALTED         = 1'b0;
      FAULT          = 1'b0;
      case (r_state)
         ST_FETCH: begin
            CTRL_REG_INSTR = 1'b1;
            CTRL_REG_ARG   = 1'b1;
         end
         ST_PC_OP: begin
            SEL_MUX_OP2  = 2'd3;
            CTRL_REG_OP2 = 1'b1;
         end
         ST_PC_WR: begin
            SEL_ULA     = 4'd4;
            CTRL_REG_PC = 1'b1;
            INSTR_DONE  = 1'b1;
         end
         ST_PUSH: begin
            SEL_MUX_STACK  = 2'd0;
            CTRL_REG_STACK = 2'b10;
            CTRL_STACK     = 1'b1;
         end
         ST_POP:  CTRL_REG_STACK = 2'b11;
         ST_RD_B: CTRL_REG_STACK = 2'b01;
         ST_LD_B: begin
            CTRL_REG_OP2   = 1'b1;
            CTRL_REG_STACK = 2'b11;
         end
         ST_RD_A: CTRL_REG_STACK = 2'b01;
         ST_LD_A: begin
            CTRL_REG_OP1   = 1'b1;
            CTRL_REG_STACK = 2'b11;
         end
         ST_ALU_WB: begin
            SEL_ULA        = r_aluSel;
            SEL_MUX_STACK  = 2'd3;
            CTRL_REG_STACK = 2'b10;
            CTRL_STACK     = 1'b1;
         end
         ST_J_OP: begin
            SEL_MUX_OP2  = 2'd1;
            CTRL_REG_OP2 = 1'b1;
         end
         ST_J_WR: begin
            SEL_ULA     = 4'd5;
            CTRL_REG_PC = 1'b1;
            INSTR_DONE  = 1'b1;
         end
         ST_HALT:  HALTED = 1'b1;
         ST_FAULT: FAULT  = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pampy_control_unit.sv
// Testbench for pampy_control_unit: randomized instruction streams checked cycle by cycle
// against a trace model built from the instruction micro-step table.
module tb_pampy_control_unit;

   typedef struct packed {
      logic [1:0] op1;
      logic [1:0] op2;
      logic       cOp1;
      logic       cOp2;
      logic [3:0] ula;
      logic       cInstr;
      logic       cArg;
      logic       cPc;
      logic       muxPc;
      logic [1:0] muxStack;
      logic [1:0] regStack;
      logic       cStack;
      logic       done;
      logic       halted;
      logic       fault;
   } ctl_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       START;
   logic [7:0] INSTR_IN;
   logic [7:0] ARG_IN;
   logic       COMP_IN;
   logic       OVERFLOW_IN;
   logic [1:0] SEL_MUX_OP1, SEL_MUX_OP2, SEL_MUX_STACK, CTRL_REG_STACK;
   logic       CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC;
   logic       SEL_MUX_PC, CTRL_STACK, INSTR_DONE, HALTED, FAULT;
   logic [3:0] SEL_ULA;

   int   errors = 0;
   int   checks = 0;
   ctl_t expQ[$];
   ctl_t actV;

   pampy_control_unit #(.DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .START(START), .INSTR_IN(INSTR_IN), .ARG_IN(ARG_IN),
      .COMP_IN(COMP_IN), .OVERFLOW_IN(OVERFLOW_IN), .SEL_MUX_OP1(SEL_MUX_OP1),
      .SEL_MUX_OP2(SEL_MUX_OP2), .CTRL_REG_OP1(CTRL_REG_OP1), .CTRL_REG_OP2(CTRL_REG_OP2),
      .SEL_ULA(SEL_ULA), .CTRL_REG_INSTR(CTRL_REG_INSTR), .CTRL_REG_ARG(CTRL_REG_ARG),
      .CTRL_REG_PC(CTRL_REG_PC), .SEL_MUX_PC(SEL_MUX_PC), .SEL_MUX_STACK(SEL_MUX_STACK),
      .CTRL_REG_STACK(CTRL_REG_STACK), .CTRL_STACK(CTRL_STACK), .INSTR_DONE(INSTR_DONE),
      .HALTED(HALTED), .FAULT(FAULT)
   );

   always #5 clk = ~clk;

   assign actV = {SEL_MUX_OP1, SEL_MUX_OP2, CTRL_REG_OP1, CTRL_REG_OP2, SEL_ULA,
                  CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC, SEL_MUX_PC, SEL_MUX_STACK,
                  CTRL_REG_STACK, CTRL_STACK, INSTR_DONE, HALTED, FAULT};

   // Appends the control word of one named micro-step to the expected trace.
   task automatic addStep(input string kind, input logic [3:0] ula = 4'd0);
      ctl_t v;
      v = '0;
      case (kind)
         "FETCH": begin v.cInstr = 1'b1; v.cArg = 1'b1; end
         "PC_OP": begin v.op2 = 2'd3; v.cOp2 = 1'b1; end
         "PC_WR": begin v.ula = 4'd4; v.cPc = 1'b1; v.done = 1'b1; end
         "PUSH":  begin v.muxStack = 2'd0; v.regStack = 2'b10; v.cStack = 1'b1; end
         "POP":   v.regStack = 2'b11;
         "RD":    v.regStack = 2'b01;
         "LD_B":  begin v.op2 = 2'd0; v.cOp2 = 1'b1; v.regStack = 2'b11; end
         "LD_A":  begin v.op1 = 2'd0; v.cOp1 = 1'b1; v.regStack = 2'b11; end
         "ALU":   begin v.ula = ula; v.muxStack = 2'd3; v.regStack = 2'b10; v.cStack = 1'b1; end
         "J_OP":  begin v.op2 = 2'd1; v.cOp2 = 1'b1; end
         "J_WR":  begin v.ula = 4'd5; v.cPc = 1'b1; v.done = 1'b1; end
         "HALT":  v.halted = 1'b1;
         "FAULT": v.fault = 1'b1;
         default: ;
      endcase
      expQ.push_back(v);
   endtask

   // Reference model: the per-cycle control trace of one instruction starting at FETCH.
   task automatic buildTrace(input logic [7:0] op, input logic [7:0] arg, input logic comp,
                             input logic ovf, output bit term);
      logic [3:0] ula;
      logic [2:0] code;
      bit         jump;
      term = 1'b0;
      jump = 1'b0;
      code = arg[2:0];
      expQ.delete();
      addStep("FETCH");
      addStep("DECODE");
      case (op)
         8'd0:   begin addStep("HALT"); term = 1'b1; end
         8'd9:   ;
         8'd100: addStep("PUSH");
         8'd1:   addStep("POP");
         8'd20, 8'd23, 8'd24, 8'd107: begin
            if (op == 8'd107 && code > 3'd5) begin
               addStep("FAULT");
               term = 1'b1;
            end else begin
               if (op == 8'd20)      ula = 4'd2;
               else if (op == 8'd23) ula = 4'd0;
               else if (op == 8'd24) ula = 4'd1;
               else                  ula = 4'd8 + {1'b0, code};
               addStep("RD"); addStep("LD_B"); addStep("RD"); addStep("LD_A");
               addStep("ALU", ula);
               if (op != 8'd107 && ovf) begin
                  addStep("PC_OP");
                  addStep("FAULT");
                  term = 1'b1;
               end
            end
         end
         8'd113: jump = 1'b1;
         8'd114: begin addStep("POP"); jump = !comp; end
         default: begin addStep("FAULT"); term = 1'b1; end
      endcase
      if (!term) begin
         if (jump) begin addStep("J_OP"); addStep("J_WR"); end
         else      begin addStep("PC_OP"); addStep("PC_WR"); end
      end
   endtask

   // Drives the inputs for the rest of trace cycle i: the real values only where they are sampled.
   task automatic applyStimulus(input int i, input logic [7:0] op, input logic [7:0] arg,
                                input logic comp, input logic ovf);
      START       = 1'($urandom);
      INSTR_IN    = (i == 1) ? op  : 8'($urandom);
      ARG_IN      = (i == 1) ? arg : 8'($urandom);
      COMP_IN     = (i == 2) ? comp : 1'($urandom);
      OVERFLOW_IN = (i == 7) ? ovf  : 1'($urandom);
   endtask

   task automatic applyReset();
      reset = 1'b1; START = 1'b0; INSTR_IN = '0; ARG_IN = '0; COMP_IN = 1'b0; OVERFLOW_IN = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      reset = 1'b1;
      #1;
      checks++;
      if (actV !== ctl_t'('0)) begin
         errors++;
         $display("[TB] FAIL reset_hold: got %h expected %h", actV, ctl_t'('0));
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (actV !== ctl_t'('0)) begin
            errors++;
            $display("[TB] FAIL reset_idle c%0d: got %h expected %h", i, actV, ctl_t'('0));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ops[10]  = '{8'd100, 8'd23, 8'd107, 8'd114, 8'd114, 8'd9, 8'd1, 8'd113, 8'd24, 8'd20};
      logic [7:0] args[10] = '{8'd5, 8'd77, 8'd2, 8'd3, 8'd3, 8'd0, 8'd8, 8'd40, 8'd1, 8'd9};
      logic       comps[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bit         term;
      applyReset();
      START = 1'b1;
      for (int n = 0; n < 10; n++) begin
         buildTrace(ops[n], args[n], comps[n], 1'b0, term);
         for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            checks++;
            if (actV !== expQ[i]) begin
               errors++;
               $display("[TB] FAIL b2b op%0d c%0d: got %h expected %h", ops[n], i, actV, expQ[i]);
            end
            applyStimulus(i, ops[n], args[n], comps[n], 1'b0);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [7:0] pool[9] = '{8'd9, 8'd100, 8'd1, 8'd20, 8'd23, 8'd24, 8'd107, 8'd113, 8'd114};
      logic [7:0] op, arg;
      logic       comp;
      bit         term;
      applyReset();
      START = 1'b1;
      for (int n = 0; n < 40; n++) begin
         op   = pool[$urandom_range(0, 8)];
         arg  = 8'($urandom);
         if (op == 8'd107) arg[2:0] = 3'($urandom_range(0, 5));
         comp = 1'($urandom);
         buildTrace(op, arg, comp, 1'b0, term);
         for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            checks++;
            if (actV !== expQ[i]) begin
               errors++;
               $display("[TB] FAIL rand op%0d c%0d: got %h expected %h", op, i, actV, expQ[i]);
            end
            applyStimulus(i, op, arg, comp, 1'b0);
         end
      end
   endtask

   task automatic test_terminal(input string name, input logic [7:0] op, input logic [7:0] arg,
                                input logic ovf);
      bit term;
      applyReset();
      START = 1'b1;
      buildTrace(op, arg, 1'b0, ovf, term);
      for (int i = 0; i < expQ.size() + 4; i++) begin
         @(negedge clk);
         checks++;
         if (actV !== expQ[(i < expQ.size()) ? i : expQ.size() - 1]) begin
            errors++;
            $display("[TB] FAIL %s c%0d: got %h expected %h", name, i, actV,
                     expQ[(i < expQ.size()) ? i : expQ.size() - 1]);
         end
         applyStimulus(i, op, arg, 1'b0, ovf);
      end
   endtask

   task automatic test_reset_mid();
      bit term;
      applyReset();
      START = 1'b1;
      buildTrace(8'd23, 8'd0, 1'b0, 1'b0, term);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (actV !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL mid_pre c%0d: got %h expected %h", i, actV, expQ[i]);
         end
         applyStimulus(i, 8'd23, 8'd0, 1'b0, 1'b0);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (actV !== ctl_t'('0)) begin
         errors++;
         $display("[TB] FAIL mid_abort: got %h expected %h", actV, ctl_t'('0));
      end
      @(negedge clk);
      reset = 1'b0;
      START = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (actV !== ctl_t'('0)) begin
            errors++;
            $display("[TB] FAIL mid_idle c%0d: got %h expected %h", i, actV, ctl_t'('0));
         end
      end
      START = 1'b1;
      buildTrace(8'd9, 8'd0, 1'b0, 1'b0, term);
      for (int i = 0; i < expQ.size(); i++) begin
         @(negedge clk);
         checks++;
         if (actV !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL mid_restart c%0d: got %h expected %h", i, actV, expQ[i]);
         end
         applyStimulus(i, 8'd9, 8'd0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] badOp;
      test_reset();
      test_back_to_back();
      test_random_stream();
      test_terminal("halt", 8'd0, 8'd33, 1'b0);
      test_terminal("cmp_arg6", 8'd107, 8'd6, 1'b0);
      test_terminal("cmp_arg7", 8'd107, 8'd15, 1'b0);
      test_terminal("mul_ovf", 8'd20, 8'd3, 1'b1);
      test_terminal("sub_ovf", 8'd24, 8'd3, 1'b1);
      do badOp = 8'($urandom);
      while (badOp inside {8'd0, 8'd1, 8'd9, 8'd20, 8'd23, 8'd24, 8'd100, 8'd107, 8'd113, 8'd114});
      test_terminal("illegal", badOp, 8'd0, 1'b0);
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
